// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            hi_we,
    output logic            lo_we,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;      // product / quotient sign
    logic              rneg_q, rneg_d;    // remainder sign
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   orig_q, orig_d;    // untouched dividend for divide-by-zero
    logic [XLEN-1:0]   a_q, a_d;          // |multiplicand| or |dividend| (shifts left in divide)
    logic [XLEN-1:0]   b_q, b_d;          // |multiplier| (shifts right) or |divisor|
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;

    logic              a_neg, b_neg, is_div;
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN+1:0]   rem_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod;
    logic [XLEN-1:0]   quo, rem, fin_quo, fin_rem;

    // Datapath step, final sign correction and next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        orig_d  = orig_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_d    = 1'b0;

        is_div = op_q[1];
        a_neg  = ~op[0] & a[XLEN-1];
        b_neg  = ~op[0] & b[XLEN-1];

        // Shift-add: add multiplicand into the upper half, then shift the
        // whole accumulator right so product bits settle from the bottom.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: upper half is the partial remainder, lower half
        // collects quotient bits; the borrow of the trial subtract decides.
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
        q_bit    = ~rem_diff[XLEN+1];
        div_next = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                    acc_q[XLEN-2:0], q_bit};

        step_acc = is_div ? div_next : mul_next;

        prod    = neg_q ? -step_acc : step_acc;
        quo     = step_acc[XLEN-1:0];
        rem     = step_acc[2*XLEN-1:XLEN];
        fin_quo = div0_q ? '1     : (neg_q  ? -quo : quo);
        fin_rem = div0_q ? orig_q : (rneg_q ? -rem : rem);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    op_d    = op;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div0_d  = (b == '0);
                    orig_d  = a;
                    a_d     = a_neg ? -a : a;
                    b_d     = b_neg ? -b : b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = step_acc;
                a_d   = is_div ? {a_q[XLEN-2:0], 1'b0} : a_q;
                b_d   = is_div ? b_q : {1'b0, b_q[XLEN-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    we_d    = 1'b1;
                    hi_d    = is_div ? fin_rem : prod[2*XLEN-1:XLEN];
                    lo_d    = is_div ? fin_quo : prod[XLEN-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            orig_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            orig_q  <= orig_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign hi_we = we_q;
    assign lo_we = we_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
